// File: rtl/uart_mmio_responder.sv
// MMIO slave for the UART window: status/data registers, TX holding register
// with valid/ready handshake, and a small RX FIFO with sticky overrun flags.
module uart_mmio_responder #(
  parameter int RX_DEPTH = 4,
  parameter int RX_AW    = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RE,
  input  logic        WE,
  input  logic [7:0]  Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady
);

  localparam logic [5:0] OFF_TXSTAT = 6'h00;
  localparam logic [5:0] OFF_RXSTAT = 6'h01;
  localparam logic [5:0] OFF_TXDATA = 6'h02;
  localparam logic [5:0] OFF_RXDATA = 6'h03;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_CLEAR  = 6'h05;

  logic [7:0]       mem [RX_DEPTH];
  logic [RX_AW-1:0] wptr;
  logic [RX_AW-1:0] rptr;
  logic [RX_AW:0]   count;
  logic             tx_ovr;
  logic             rx_ovr;

  logic [5:0]  off;
  logic        non_empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        rx_drop;
  logic        hs;
  logic        tx_wr;
  logic        tx_accept;
  logic        tx_drop;
  logic        clr_wr;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign unused_bits = ^{Addr[1:0], WData[31:8]};

  assign off       = Addr[7:2];
  assign non_empty = (count != '0);
  // count never exceeds RX_DEPTH, so its top bit alone marks full
  assign full      = count[RX_AW];
  assign pop       = RE && (off == OFF_RXDATA) && non_empty;
  assign push      = RxValid && (!full || pop);
  assign rx_drop   = RxValid && full && !pop;
  assign hs        = TxValid && TxReady;
  assign tx_wr     = WE && (off == OFF_TXDATA);
  assign tx_accept = tx_wr && (!TxValid || hs);
  assign tx_drop   = tx_wr && TxValid && !hs;
  assign clr_wr    = WE && (off == OFF_CLEAR);

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_TXSTAT: rd_val[0] = ~TxValid;
      OFF_RXSTAT: rd_val[0] = non_empty;
      OFF_RXDATA: if (non_empty) rd_val[7:0] = mem[rptr];
      OFF_STATUS: begin
        rd_val[RX_AW:0] = count;
        rd_val[8]       = tx_ovr;
        rd_val[9]       = rx_ovr;
      end
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset && push) mem[wptr] <= RxData;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      RData   <= '0;
      TxData  <= '0;
      TxValid <= 1'b0;
      RxReady <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      tx_ovr  <= 1'b0;
      rx_ovr  <= 1'b0;
    end else begin
      RxReady <= 1'b1;
      if (RE) RData <= rd_val;

      if (tx_accept) begin
        TxData  <= WData[7:0];
        TxValid <= 1'b1;
      end else if (hs) begin
        TxValid <= 1'b0;
      end

      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      // a new overrun on the clearing edge wins over the clear
      tx_ovr <= (tx_ovr && !(clr_wr && WData[0])) || tx_drop;
      rx_ovr <= (rx_ovr && !(clr_wr && WData[1])) || rx_drop;
    end
  end

endmodule
